// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU request at a time over the shared bus (load A, load B, exec, latch, read back).
// Optional `ALU_SEQ_PERF_EN adds a saturating completed-op counter on op_count.
`timescale 1ns/1ps
module alu_sequencer #(
   parameter int DATA_W      = 16,
   parameter int OP_W        = 3,
   parameter int EXEC_CYCLES = 1
`ifdef ALU_SEQ_PERF_EN
   ,
   parameter int CNT_W       = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [OP_W-1:0]   opControl,
   output logic              ALUin0,
   output logic              ALUin1,
   output logic              ALUOutLatch,
   output logic              ALUOutEn,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   input  logic [DATA_W-1:0] bus_in,
   output logic              busy
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0]  op_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_EXEC   = 3'd3,
      S_LATCH  = 3'd4,
      S_READ   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
      $error("alu_sequencer: EXEC_CYCLES=%0d outside legal range 1..15", EXEC_CYCLES);
   end

   state_t            state_r;
   state_t            state_s;
   logic [3:0]        exec_cnt_r;
   logic [3:0]        exec_cnt_s;
   logic [DATA_W-1:0] b_r;
   logic              accept_s;
   logic [DATA_W-1:0] bus_out_s;

   // next-state and exec countdown
   always_comb begin
      state_s    = state_r;
      exec_cnt_s = exec_cnt_r;
      accept_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept_s = 1'b1;
               state_s  = S_LOAD_A;
            end else begin
               state_s  = S_IDLE;
            end
         end
         S_LOAD_A: state_s = S_LOAD_B;
         S_LOAD_B: begin
            state_s    = S_EXEC;
            exec_cnt_s = EXEC_LOAD;
         end
         S_EXEC: begin
            if (exec_cnt_r == 4'd0) begin
               state_s = S_LATCH;
            end else begin
               exec_cnt_s = exec_cnt_r - 4'd1;
            end
         end
         S_LATCH: state_s = S_READ;
         S_READ:  state_s = S_DONE;
         S_DONE: begin
            if (rsp_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // LOAD_A is only entered from an accept, so the operand comes straight off the request
   always_comb begin
      bus_out_s = {DATA_W{1'b0}};
      case (state_s)
         S_LOAD_A: bus_out_s = req_a;
         S_LOAD_B: bus_out_s = b_r;
         default:  bus_out_s = {DATA_W{1'b0}};
      endcase
   end

   // state and exec counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         exec_cnt_r <= 4'd0;
      end else begin
         state_r    <= state_s;
         exec_cnt_r <= exec_cnt_s;
      end
   end

   // operand B and opcode captured on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_r       <= {DATA_W{1'b0}};
         opControl <= {OP_W{1'b0}};
      end else if (accept_s) begin
         b_r       <= req_b;
         opControl <= req_op;
      end else begin
         b_r       <= b_r;
         opControl <= opControl;
      end
   end

   // strobes and handshakes are registered decodes of the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready   <= 1'b0;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         ALUin0      <= 1'b0;
         ALUin1      <= 1'b0;
         ALUOutLatch <= 1'b0;
         ALUOutEn    <= 1'b0;
         bus_oe      <= 1'b0;
         bus_out     <= {DATA_W{1'b0}};
      end else begin
         req_ready   <= (state_s == S_IDLE);
         busy        <= (state_s != S_IDLE);
         rsp_valid   <= (state_s == S_DONE);
         ALUin0      <= (state_s == S_LOAD_A);
         ALUin1      <= (state_s == S_LOAD_B);
         ALUOutLatch <= (state_s == S_LATCH);
         ALUOutEn    <= (state_s == S_READ);
         bus_oe      <= (state_s == S_LOAD_A) || (state_s == S_LOAD_B);
         bus_out     <= bus_out_s;
      end
   end

   // result captured from the bus while the ALU drives it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data <= {DATA_W{1'b0}};
      end else if (state_r == S_READ) begin
         rsp_data <= bus_in;
      end else begin
         rsp_data <= rsp_data;
      end
   end

`ifdef ALU_SEQ_PERF_EN
   // saturating count of completed DONE->IDLE handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= {CNT_W{1'b0}};
      end else if (state_r == S_DONE && rsp_ready && op_count != {CNT_W{1'b1}}) begin
         op_count <= op_count + CNT_W'(1);
      end else begin
         op_count <= op_count;
      end
   end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU on the bus.
`timescale 1ns/1ps
module tb_alu_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2:0]  req_op, opControl;
   logic [15:0] req_a, req_b, rsp_data, bus_out, bus_in;
   logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn, bus_oe, busy;
`ifdef ALU_SEQ_PERF_EN
   logic [1:0]  op_count;
`endif

   logic        x_req_valid, x_req_ready, x_rsp_valid, x_rsp_ready;
   logic [2:0]  x_req_op, x_opControl;
   logic [15:0] x_req_a, x_req_b, x_rsp_data, x_bus_out, x_bus_in;
   logic        x_ALUin0, x_ALUin1, x_ALUOutLatch, x_ALUOutEn, x_bus_oe, x_busy;
`ifdef ALU_SEQ_PERF_EN
   logic [15:0] x_op_count;
`endif

   alu_sequencer #(.DATA_W(16), .OP_W(3), .EXEC_CYCLES(1)
`ifdef ALU_SEQ_PERF_EN
      , .CNT_W(2)
`endif
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .opControl(opControl),
      .ALUin0(ALUin0), .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
      .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .busy(busy)
`ifdef ALU_SEQ_PERF_EN
      , .op_count(op_count)
`endif
   );

   alu_sequencer #(.DATA_W(16), .OP_W(3), .EXEC_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(x_req_valid), .req_ready(x_req_ready),
      .req_op(x_req_op), .req_a(x_req_a), .req_b(x_req_b), .rsp_valid(x_rsp_valid),
      .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data), .opControl(x_opControl),
      .ALUin0(x_ALUin0), .ALUin1(x_ALUin1), .ALUOutLatch(x_ALUOutLatch), .ALUOutEn(x_ALUOutEn),
      .bus_out(x_bus_out), .bus_oe(x_bus_oe), .bus_in(x_bus_in), .busy(x_busy)
`ifdef ALU_SEQ_PERF_EN
      , .op_count(x_op_count)
`endif
   );

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0:    alu_f = a + b;
         3'd1:    alu_f = a - b;
         3'd2:    alu_f = a & b;
         3'd3:    alu_f = a | b;
         3'd4:    alu_f = a ^ b;
         default: alu_f = a;
      endcase
   endfunction

   logic [15:0] m_a, m_b, m_res, x_a, x_b, x_res;
   always @(posedge clk) begin
      if (ALUin0)        m_a   <= bus_out;
      if (ALUin1)        m_b   <= bus_out;
      if (ALUOutLatch)   m_res <= alu_f(opControl, m_a, m_b);
      if (x_ALUin0)      x_a   <= x_bus_out;
      if (x_ALUin1)      x_b   <= x_bus_out;
      if (x_ALUOutLatch) x_res <= alu_f(x_opControl, x_a, x_b);
   end
   assign bus_in   = ALUOutEn   ? m_res : 16'hDEAD;
   assign x_bus_in = x_ALUOutEn ? x_res : 16'hDEAD;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   logic inv_ok;
   always @(negedge clk) begin
      if (!rst) begin
         inv_ok = !(bus_oe && ALUOutEn) && ($countones({ALUin0, ALUin1, ALUOutLatch, ALUOutEn}) <= 1)
                  && (bus_oe || bus_out == 16'h0000);
         check("invariant", {31'd0, inv_ok}, 32'd1);
      end
   end

   task automatic start(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      @(negedge clk);
      acc_cyc = cyc;
      req_valid = 1'b0; req_a = 16'h5A5A; req_b = 16'hA5A5; req_op = 3'd7;
      check("acc_busy", {31'd0, busy}, 32'd1);
      check("loada_in0", {31'd0, ALUin0}, 32'd1);
      check("loada_oe", {31'd0, bus_oe}, 32'd1);
      check("loada_bus", {16'd0, bus_out}, {16'd0, a});
      check("opcontrol", {29'd0, opControl}, {29'd0, op});
   endtask

   task automatic wait_rsp(input int exp_lat, input logic [15:0] exp_data);
      while (!rsp_valid && (cyc - acc_cyc) < 30) @(negedge clk);
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("latency", cyc - acc_cyc, exp_lat);
      check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   logic [2:0]  t_op [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
   logic [15:0] t_a  [4] = '{16'h1200, 16'hFFFF, 16'h0000, 16'hFFFF};
   logic [15:0] t_b  [4] = '{16'h0034, 16'h00F0, 16'h0001, 16'h0001};
   logic [15:0] t_r  [4] = '{16'h1234, 16'h00F0, 16'hFFFF, 16'h0000};

   initial begin
      req_valid = 1'b0; req_op = 3'd0; req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b0;
      x_req_valid = 1'b0; x_req_op = 3'd0; x_req_a = 16'h0; x_req_b = 16'h0; x_rsp_ready = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_outs", {22'd0, rsp_valid, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, bus_oe, opControl, 1'b0}, 32'd0);
      check("rst_data", {bus_out, rsp_data}, 32'd0);
`ifdef ALU_SEQ_PERF_EN
      check("rst_count", {30'd0, op_count}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // ADD 3+4 with held response
      start(3'd0, 16'h0003, 16'h0004);
      @(negedge clk);
      check("loadb_in1", {31'd0, ALUin1}, 32'd1);
      check("loadb_bus", {16'd0, bus_out}, 32'h0004);
      wait_rsp(5, 16'h0007);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_data", {16'd0, rsp_data}, 32'h0007);
         check("hold_ready", {31'd0, req_ready}, 32'd0);
      end
      finish_rsp();

      // request pulsed during LOAD_B is ignored
      start(3'd1, 16'h0010, 16'h0003);
      @(negedge clk);
      req_valid = 1'b1; req_a = 16'hFFFF;
      @(negedge clk);
      req_valid = 1'b0;
      check("ign_ready", {31'd0, req_ready}, 32'd0);
      wait_rsp(5, 16'h000D);
      finish_rsp();
      repeat (6) @(negedge clk);
      check("ign_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("ign_no_busy", {31'd0, busy}, 32'd0);

      // reset during EXEC
      start(3'd2, 16'h00FF, 16'h0F0F);
      @(negedge clk); @(negedge clk);
      check("exec_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_outs", {26'd0, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, bus_oe, rsp_valid}, 32'd0);
      check("abort_op", {29'd0, opControl}, 32'd0);
      check("abort_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_idle_ready", {31'd0, req_ready}, 32'd1);
      repeat (8) @(negedge clk);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_SEQ_PERF_EN
      check("abort_count", {30'd0, op_count}, 32'd0);
`endif

      // XOR then table of ops, counting completions
      start(3'd4, 16'hA5A5, 16'h0FF0);
      wait_rsp(5, 16'hAA55);
      finish_rsp();
`ifdef ALU_SEQ_PERF_EN
      check("count1", {30'd0, op_count}, 32'd1);
`endif
      for (int i = 0; i < 4; i++) begin
         start(t_op[i], t_a[i], t_b[i]);
         wait_rsp(5, t_r[i]);
         finish_rsp();
`ifdef ALU_SEQ_PERF_EN
         check("count_sat", {30'd0, op_count}, (i + 2 > 3) ? 32'd3 : 32'(i + 2));
`endif
      end

      // EXEC_CYCLES=3 instance: 0x8000+0x8000
      @(negedge clk);
      x_req_op = 3'd0; x_req_a = 16'h8000; x_req_b = 16'h8000; x_req_valid = 1'b1;
      @(negedge clk);
      acc_cyc = cyc;
      x_req_valid = 1'b0; x_req_a = 16'h1111; x_req_b = 16'h2222;
      check("x_loada_bus", {16'd0, x_bus_out}, 32'h8000);
      while (!x_rsp_valid && (cyc - acc_cyc) < 30) @(negedge clk);
      check("x_rsp_valid", {31'd0, x_rsp_valid}, 32'd1);
      check("x_latency", cyc - acc_cyc, 32'd7);
      check("x_rsp_data", {16'd0, x_rsp_data}, 32'h0000);
      x_rsp_ready = 1'b1;
      @(negedge clk);
      x_rsp_ready = 1'b0;
      check("x_idle", {30'd0, x_rsp_valid, x_busy}, 32'd0);

`ifdef ALU_SEQ_PERF_EN
      rst = 1'b1;
      @(negedge clk);
      check("count_rst", {30'd0, op_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
